// File: rtl/rename_retire_ctrl.sv
// Active-list sequencer for register renaming: in-order commit to the free list and
// backward mispredict walk restoring the RMT. Optional perf counters: RENAME_RETIRE_PERF_EN.
module rename_retire_ctrl #(
   parameter  int NUM_ARCH_REGS = 32,
   parameter  int NUM_PHYS_REGS = 64,
   parameter  int AL_DEPTH      = 32,
   localparam int ARCH_W        = $clog2(NUM_ARCH_REGS),
   localparam int PHYS_W        = $clog2(NUM_PHYS_REGS),
   localparam int IDX_W         = $clog2(AL_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alloc_valid,
   input  logic [ARCH_W-1:0] alloc_arch,
   input  logic [PHYS_W-1:0] alloc_new_phys,
   input  logic [PHYS_W-1:0] alloc_old_phys,
   output logic              alloc_ready,
   output logic [IDX_W-1:0]  alloc_idx,
   input  logic              done_valid,
   input  logic [IDX_W-1:0]  done_idx,
   input  logic              flush_valid,
   input  logic [IDX_W-1:0]  flush_idx,
   output logic              fl_push_valid,
   output logic [PHYS_W-1:0] fl_push_phys,
   output logic              rmt_wr_en,
   output logic [ARCH_W-1:0] rmt_wr_arch,
   output logic [PHYS_W-1:0] rmt_wr_phys,
   output logic              commit_valid,
   output logic [ARCH_W-1:0] commit_arch,
   output logic [PHYS_W-1:0] commit_phys,
   output logic              recovering,
`ifdef RENAME_RETIRE_PERF_EN
   output logic [31:0]       perf_commits,
   output logic [31:0]       perf_squashed,
   output logic [31:0]       perf_walk_cycles,
`endif
   output logic [IDX_W:0]    al_count
);

   typedef enum logic {ST_RUN, ST_WALK} state_e;

   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(AL_DEPTH);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d, target_q, target_d;
   logic [IDX_W:0]       count_q, count_d;
   logic [AL_DEPTH-1:0]  valid_q, valid_d, done_q, done_d;

   logic [ARCH_W-1:0]    arch_mem [AL_DEPTH];
   logic [PHYS_W-1:0]    new_mem  [AL_DEPTH];
   logic [PHYS_W-1:0]    old_mem  [AL_DEPTH];

   logic                 alloc_fire, commit_fire, walk_pop, adopt;
   logic [IDX_W-1:0]     walk_idx, tgt_eff, flush_age, target_age;

   // Handshake: an allocation transfers on a clock edge where alloc_valid && alloc_ready;
   // alloc_ready never depends on alloc_valid, and the other inputs are single-cycle strobes.
   always_comb begin
      state_d       = state_q;
      head_d        = head_q;
      tail_d        = tail_q;
      target_d      = target_q;
      count_d       = count_q;
      valid_d       = valid_q;
      done_d        = done_q;
      fl_push_valid = 1'b0;
      fl_push_phys  = '0;
      rmt_wr_en     = 1'b0;
      rmt_wr_arch   = '0;
      rmt_wr_phys   = '0;
      commit_valid  = 1'b0;
      commit_arch   = '0;
      commit_phys   = '0;

      walk_idx    = tail_q - IDX_ONE;
      flush_age   = flush_idx - head_q;
      target_age  = target_q - head_q;
      alloc_ready = (state_q == ST_RUN) && (count_q < FULL_CNT) && !flush_valid;
      alloc_fire  = alloc_valid && alloc_ready;
      commit_fire = (state_q == ST_RUN) && valid_q[head_q] && done_q[head_q];
      walk_pop    = (state_q == ST_WALK) && (count_q != '0);
      adopt       = (state_q == ST_WALK) && flush_valid && (flush_age < target_age);
      tgt_eff     = adopt ? flush_idx : target_q;
      recovering  = (state_q == ST_WALK);
      alloc_idx   = tail_q;
      al_count    = count_q;

      if (done_valid && valid_q[done_idx]) done_d[done_idx] = 1'b1;

      if (commit_fire) begin
         fl_push_valid    = 1'b1;
         fl_push_phys     = old_mem[head_q];
         commit_valid     = 1'b1;
         commit_arch      = arch_mem[head_q];
         commit_phys      = new_mem[head_q];
         valid_d[head_q]  = 1'b0;
         head_d           = head_q + IDX_ONE;
      end

      case (state_q)
         ST_RUN: begin
            if (flush_valid && (tail_q != flush_idx + IDX_ONE)) begin
               state_d  = ST_WALK;
               target_d = flush_idx;
            end
         end
         ST_WALK: begin
            target_d = tgt_eff;
            if (walk_pop) begin
               rmt_wr_en         = 1'b1;
               rmt_wr_arch       = arch_mem[walk_idx];
               rmt_wr_phys       = old_mem[walk_idx];
               fl_push_valid     = 1'b1;
               fl_push_phys      = new_mem[walk_idx];
               valid_d[walk_idx] = 1'b0;
               tail_d            = walk_idx;
               if (walk_idx == tgt_eff + IDX_ONE) state_d = ST_RUN;
            end else begin
               // Nothing left to squash; never sit in WALK with an empty list.
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase

      if (alloc_fire) begin
         valid_d[tail_q] = 1'b1;
         done_d[tail_q]  = 1'b0;
         tail_d          = tail_q + IDX_ONE;
      end

      // Commit and walk are exclusive by state, so at most one removal per cycle.
      if (alloc_fire && !(commit_fire || walk_pop))      count_d = count_q + 1'b1;
      else if (!alloc_fire && (commit_fire || walk_pop)) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         head_q   <= '0;
         tail_q   <= '0;
         target_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
         done_q   <= '0;
      end else begin
         state_q  <= state_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         target_q <= target_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         arch_mem[tail_q] <= alloc_arch;
         new_mem[tail_q]  <= alloc_new_phys;
         old_mem[tail_q]  <= alloc_old_phys;
      end
   end

`ifdef RENAME_RETIRE_PERF_EN
   logic [31:0] perf_commits_q, perf_commits_d;
   logic [31:0] perf_squashed_q, perf_squashed_d;
   logic [31:0] perf_walk_cycles_q, perf_walk_cycles_d;

   always_comb begin
      perf_commits_d     = perf_commits_q + {31'd0, commit_fire};
      perf_squashed_d    = perf_squashed_q + {31'd0, walk_pop};
      perf_walk_cycles_d = perf_walk_cycles_q + {31'd0, recovering};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_commits_q     <= '0;
         perf_squashed_q    <= '0;
         perf_walk_cycles_q <= '0;
      end else begin
         perf_commits_q     <= perf_commits_d;
         perf_squashed_q    <= perf_squashed_d;
         perf_walk_cycles_q <= perf_walk_cycles_d;
      end
   end

   assign perf_commits     = perf_commits_q;
   assign perf_squashed    = perf_squashed_q;
   assign perf_walk_cycles = perf_walk_cycles_q;
`endif

endmodule

// File: tb/tb_rename_retire_ctrl.sv
// Scoreboard bench for rename_retire_ctrl: a queue-based active-list model predicts
// per-cycle status and the commit / free-list / RMT event streams checked by a monitor.
module tb_rename_retire_ctrl;
  localparam int D      = 32;
  localparam int ARCH_W = 5;
  localparam int PHYS_W = 6;
  localparam int IDX_W  = 5;
  localparam int STAT_W = 1 + IDX_W + (IDX_W + 1) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              alloc_valid = 1'b0;
  logic [ARCH_W-1:0] alloc_arch = '0;
  logic [PHYS_W-1:0] alloc_new_phys = '0;
  logic [PHYS_W-1:0] alloc_old_phys = '0;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_idx;
  logic              done_valid = 1'b0;
  logic [IDX_W-1:0]  done_idx = '0;
  logic              flush_valid = 1'b0;
  logic [IDX_W-1:0]  flush_idx = '0;
  logic              fl_push_valid;
  logic [PHYS_W-1:0] fl_push_phys;
  logic              rmt_wr_en;
  logic [ARCH_W-1:0] rmt_wr_arch;
  logic [PHYS_W-1:0] rmt_wr_phys;
  logic              commit_valid;
  logic [ARCH_W-1:0] commit_arch;
  logic [PHYS_W-1:0] commit_phys;
  logic              recovering;
  logic [IDX_W:0]    al_count;
`ifdef RENAME_RETIRE_PERF_EN
  logic [31:0]       perf_commits, perf_squashed, perf_walk_cycles;
`endif

  // clock / reset
  always #5 clk = ~clk;

  rename_retire_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_arch(alloc_arch),
    .alloc_new_phys(alloc_new_phys), .alloc_old_phys(alloc_old_phys),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .done_valid(done_valid), .done_idx(done_idx),
    .flush_valid(flush_valid), .flush_idx(flush_idx),
    .fl_push_valid(fl_push_valid), .fl_push_phys(fl_push_phys),
    .rmt_wr_en(rmt_wr_en), .rmt_wr_arch(rmt_wr_arch), .rmt_wr_phys(rmt_wr_phys),
    .commit_valid(commit_valid), .commit_arch(commit_arch), .commit_phys(commit_phys),
    .recovering(recovering),
`ifdef RENAME_RETIRE_PERF_EN
    .perf_commits(perf_commits), .perf_squashed(perf_squashed),
    .perf_walk_cycles(perf_walk_cycles),
`endif
    .al_count(al_count)
  );

  // reference model: active list as a queue, oldest entry first
  typedef struct {
    int arch;
    int np;
    int op;
    bit done;
  } ent_t;

  ent_t al[$];
  int   m_head = 0;
  bit   m_walk = 1'b0;
  int   m_tgt  = 0;

  logic [STAT_W-1:0]        exp_stat_q[$];
  logic [ARCH_W+PHYS_W-1:0] exp_commit_q[$];
  logic [PHYS_W-1:0]        exp_push_q[$];
  logic [ARCH_W+PHYS_W-1:0] exp_rmt_q[$];

  int checks = 0;
  int errors = 0;

  function automatic int age(int i);
    return (i - m_head + D) % D;
  endfunction

  function automatic void check(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // driver: one call = one clock cycle of stimulus plus the model's prediction for it
  task automatic step(bit rst, bit av, int a, int np, int op,
                      bit dv, int di, bit fv, int fi);
    int   size;
    int   tail;
    int   t;
    bit   ready;
    bit   commit;
    bit   pop;
    ent_t e;
    @(posedge clk);
    #1;
    rst_n          = !rst;
    alloc_valid    = rst ? 1'b0 : av;
    alloc_arch     = ARCH_W'(a);
    alloc_new_phys = PHYS_W'(np);
    alloc_old_phys = PHYS_W'(op);
    done_valid     = rst ? 1'b0 : dv;
    done_idx       = IDX_W'(di);
    flush_valid    = rst ? 1'b0 : fv;
    flush_idx      = IDX_W'(fi);
    if (rst) begin
      al.delete();
      m_head = 0;
      m_walk = 1'b0;
      m_tgt  = 0;
      exp_stat_q.push_back({1'b1, IDX_W'(0), (IDX_W+1)'(0), 1'b0});
      return;
    end
    size   = al.size();
    tail   = (m_head + size) % D;
    ready  = !m_walk && (size < D) && !fv;
    commit = !m_walk && (size > 0) && al[0].done;
    pop    = m_walk && (size > 0);
    exp_stat_q.push_back({ready, IDX_W'(tail), (IDX_W+1)'(size), m_walk});
    if (commit) begin
      exp_commit_q.push_back({ARCH_W'(al[0].arch), PHYS_W'(al[0].np)});
      exp_push_q.push_back(PHYS_W'(al[0].op));
    end
    if (pop) begin
      e = al[size-1];
      exp_rmt_q.push_back({ARCH_W'(e.arch), PHYS_W'(e.op)});
      exp_push_q.push_back(PHYS_W'(e.np));
    end
    if (dv && age(di) < size) al[age(di)].done = 1'b1;
    if (!m_walk) begin
      if (fv && tail != (fi + 1) % D) begin
        m_walk = 1'b1;
        m_tgt  = fi;
      end
    end else begin
      t = (fv && age(fi) < age(m_tgt)) ? fi : m_tgt;
      m_tgt = t;
      if (pop) begin
        void'(al.pop_back());
        if ((tail - 1 + D) % D == (t + 1) % D) m_walk = 1'b0;
      end else begin
        m_walk = 1'b0;
      end
    end
    if (commit) begin
      void'(al.pop_front());
      m_head = (m_head + 1) % D;
    end
    if (av && ready) begin
      e.arch = a; e.np = np; e.op = op; e.done = 1'b0;
      al.push_back(e);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(int a, int np, int op);
    step(0, 1, a, np, op, 0, 0, 0, 0);
  endtask

  task automatic alloc_rand(int n);
    for (int i = 0; i < n; i++)
      alloc($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [STAT_W-1:0]        st;
    logic [ARCH_W+PHYS_W-1:0] ev;
    logic [PHYS_W-1:0]        ph;
    if (exp_stat_q.size() > 0) begin
      st = exp_stat_q.pop_front();
      check("status{ready,idx,count,recovering}",
            16'({alloc_ready, alloc_idx, al_count, recovering}), 16'(st));
    end
    if (fl_push_valid === 1'b1) begin
      if (exp_push_q.size() == 0) check("fl_push_unexpected", 16'(fl_push_phys), 16'hffff);
      else begin
        ph = exp_push_q.pop_front();
        check("fl_push_phys", 16'(fl_push_phys), 16'(ph));
      end
    end
    if (commit_valid === 1'b1) begin
      if (exp_commit_q.size() == 0) check("commit_unexpected", 16'({commit_arch, commit_phys}), 16'hffff);
      else begin
        ev = exp_commit_q.pop_front();
        check("commit{arch,phys}", 16'({commit_arch, commit_phys}), 16'(ev));
      end
    end
    if (rmt_wr_en === 1'b1) begin
      if (exp_rmt_q.size() == 0) check("rmt_unexpected", 16'({rmt_wr_arch, rmt_wr_phys}), 16'hffff);
      else begin
        ev = exp_rmt_q.pop_front();
        check("rmt_wr{arch,phys}", 16'({rmt_wr_arch, rmt_wr_phys}), 16'(ev));
      end
    end
  end

  initial begin
    int  sz, di, fi;
    bit  av, dv, fv;

    // basic allocate / complete / commit
    do_reset(2);
    alloc(3, 40, 3);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(2);

    // fill to full, commit one, allocation wraps to index 0
    do_reset(1);
    alloc_rand(32);
    alloc(1, 2, 3);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 4, 5, 6, 0, 0, 0, 0);
    alloc(9, 10, 11);
    idle(1);

    // mispredict at 2 with six entries: three walk cycles
    do_reset(1);
    alloc_rand(5);
    alloc(7, 50, 20);
    step(0, 0, 0, 0, 0, 0, 0, 1, 2);
    idle(5);

    // flush at tail-1: nothing to squash
    do_reset(1);
    alloc_rand(6);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5);
    idle(3);

    // older flush adopted mid-walk, younger flush ignored mid-walk
    do_reset(1);
    alloc_rand(8);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(8);
    alloc_rand(8);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 0, 0, 1, 6);
    idle(8);

    // head commit in the flush cycle, then reset in the middle of the walk
    do_reset(1);
    alloc_rand(10);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    do_reset(1);
    idle(2);

    // randomized traffic
    do_reset(1);
    for (int n = 0; n < 3000; n++) begin
      sz = al.size();
      av = ($urandom_range(0, 99) < 60);
      dv = ($urandom_range(0, 99) < 55);
      if (sz > 0 && $urandom_range(0, 3) != 0)
        di = (m_head + $urandom_range(0, (sz - 1 < 3) ? sz - 1 : 3)) % D;
      else if (sz > 0 && $urandom_range(0, 1) == 1)
        di = (m_head + $urandom_range(0, sz - 1)) % D;
      else
        di = $urandom_range(0, D - 1);
      fv = (sz > 0) && ($urandom_range(0, 99) < 4);
      fi = (sz > 0) ? (m_head + $urandom_range(0, sz - 1)) % D : 0;
      step(0, av, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63),
           dv, di, fv, fi);
    end
    idle(40);
    @(posedge clk);
    @(negedge clk);
    #1;

    check("leftover_stat", 16'(exp_stat_q.size()), 16'd0);
    check("leftover_commit", 16'(exp_commit_q.size()), 16'd0);
    check("leftover_push", 16'(exp_push_q.size()), 16'd0);
    check("leftover_rmt", 16'(exp_rmt_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
